busca_instrucao: RTL and testbench
==================================

Name: busca_instrucao

Overview:
- Instruction fetch/issue stage directly upstream of the control unit.
- Holds the program counter and reads 8-bit instruction bytes from a synchronous program memory with 1-cycle read latency.
- Splits each byte into opcode[7:4] and operando[3:0] and presents them to the control unit, then waits for the unit's completion pulse before fetching the next instruction.
- Resolves JUMP and HALT locally; these are never issued downstream.

Parameters:
- PC_W, 4, program counter and program address width (16-entry program memory).
- DATA_W, 8, instruction byte width; opcode = upper 4 bits, operando = lower 4 bits.
- OP_JUMP, 4'b1110, opcode that loads PC from operando.
- OP_HALT, 4'b1111, opcode that stops fetching.

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  begin fetching from PC=0; sampled only in IDLE.
- progAddr  output  PC_W  program memory address.
- progRd  output  1  program memory read strobe.
- progData  input  DATA_W  instruction byte; valid the cycle after progRd.
- opcode  output  4  opcode issued to the control unit.
- operando  output  4  operand issued to the control unit.
- instrValid  output  1  opcode/operando valid and held.
- ucDone  input  1  control unit completion (flagUC); level, sampled in ISSUE only.
- halted  output  1  HALT executed.
- pcOut  output  PC_W  current PC, for debug.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, pc=0, progAddr=0, progRd=0, opcode=0, operando=0, instrValid=0, halted=0, pcOut=0. This applies mid-operation too; any in-flight fetch or issue is abandoned.
- States: IDLE, FETCH, MEM_WAIT, DECODE, ISSUE, HALTED.
- IDLE: if start=1 -> FETCH; otherwise stay.
- FETCH (1 cycle): progRd=1, progAddr=pc -> MEM_WAIT.
- MEM_WAIT (1 cycle): progRd=0; latch progData into an internal instruction register -> DECODE.
- DECODE (1 cycle):
  - instr[7:4]==OP_HALT -> HALTED; halted=1 from next cycle.
  - instr[7:4]==OP_JUMP -> pc<=instr[3:0] -> FETCH.
  - Otherwise -> ISSUE; opcode/operando registered and instrValid=1 on the same edge.
- ISSUE:
  - Hold opcode/operando/instrValid stable until ucDone=1 is sampled.
  - On that edge: instrValid<=0, opcode<=0, operando<=0, pc<=pc+1 -> FETCH.
- HALTED: terminal until reset; start and ucDone ignored; pc frozen at the HALT address.
- Between issues opcode/operando are forced to 4'b0000 (NOP) for at least 3 cycles. Back-to-back identical instructions therefore always produce an opcode change at the control unit.
- Latency:
  - instrValid rises 3 edges after the edge that samples start.
  - Each subsequent issue follows 3 edges after the ucDone-sampling edge.
  - A JUMP adds 3 edges before the target instruction issues.
- Arithmetic: pc+1 is modulo 2^PC_W (15 -> 0 wrap, no flag). A jump to the current address is legal and loops.
- ucDone=1 already high on ISSUE entry: completes at the first ISSUE edge, so instrValid is high exactly 1 cycle.
- ucDone outside ISSUE: ignored, no side effects.
- start during non-IDLE states: ignored.
- Opcode 4'b0000 fetched from memory: issued like any other opcode.
- pcOut = pc at all times.

Decomposition:
- Shared package (processador_pkg):
  - opcode constants OP_NOP=4'b0000, OP_STORE=4'b1100, OP_LOAD=4'b1101, OP_JUMP, OP_HALT
  - fetch state encoding (3-bit)
  - PC_W/DATA_W defaults
- One sub-module: contador_programa. PC register with async active-low reset, synchronous load (jump) and increment enables; load has priority if both are asserted.

Test Plan:
- Reset: hold reset_n=0 mid-ISSUE -> all outputs 0 immediately (asynchronously), state IDLE; after release with start=0, progRd stays 0.
- Straight-line: mem[0]=8'hC3, mem[1]=8'hD5, mem[2]=8'hF0; pulse start; ucDone pulses 2 cycles after each instrValid rise:
  - issues {C,3} then {D,5}
  - opcode=0 between them
  - halted=1 with pcOut=2
  - progRd asserted exactly 3 times
- Jump: mem[0]=8'hE9, mem[9]=8'hC1, mem[10]=8'hF0 -> first issue is {C,1} 6 edges after start; pcOut passes 0,9,10; address 1 never read.
- Wrap: mem[15]=8'hC7, mem[0]=8'hD2, entered via mem[0]=8'hEF on first pass (mem rewritten before the wrap) -> after {C,7} completes, pcOut=0 and the next progAddr=0.
- ucDone held high constantly -> each instrValid pulse is exactly 1 cycle; issue period 4 cycles.
- Identical back-to-back: mem[0]=mem[1]=8'hC4 -> opcode goes C -> 0 -> C; two distinct instrValid pulses.

Source files
------------

// File: rtl/processador_pkg.sv
// Shared definitions for the processor front end:
// opcode map, fetch-stage state encoding and width defaults.
package processador_pkg;

  localparam int PC_W_DEF   = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b1100;
  localparam logic [3:0] OP_LOAD  = 4'b1101;
  localparam logic [3:0] OP_JUMP  = 4'b1110;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_MEM_WAIT = 3'd2,
    ST_DECODE   = 3'd3,
    ST_ISSUE    = 3'd4,
    ST_HALTED   = 3'd5
  } fetch_state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] operando;
  } instr_t;

endpackage

// File: rtl/busca_instrucao_if.sv
// Fetch-stage bus: program memory read port plus the
// instruction issue handshake towards the control unit.
interface busca_instrucao_if
  import processador_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [PC_W-1:0]   progAddr;
  logic              progRd;
  logic [DATA_W-1:0] progData;
  logic [3:0]        opcode;
  logic [3:0]        operando;
  logic              instrValid;
  logic              ucDone;

  modport master (
    output progAddr,
    output progRd,
    input  progData,
    output opcode,
    output operando,
    output instrValid,
    input  ucDone
  );

  modport slave (
    input  progAddr,
    input  progRd,
    output progData,
    input  opcode,
    input  operando,
    input  instrValid,
    output ucDone
  );

endinterface

// File: rtl/contador_programa.sv
// Program counter: jump load wins over increment,
// increment wraps modulo 2^PC_W.
module contador_programa
  import processador_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_load,
  input  logic            i_inc,
  input  logic [PC_W-1:0] i_din,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_din;
    end else if (i_inc) begin
      r_pc <= r_pc + 1'b1;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/busca_instrucao.sv
// Instruction fetch/issue stage: fetches bytes, resolves
// JUMP/HALT locally, issues the rest to the control unit.
module busca_instrucao #(
  parameter int         PC_W    = processador_pkg::PC_W_DEF,
  parameter int         DATA_W  = processador_pkg::DATA_W_DEF,
  parameter logic [3:0] OP_JUMP = processador_pkg::OP_JUMP,
  parameter logic [3:0] OP_HALT = processador_pkg::OP_HALT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              halted,
  output logic [PC_W-1:0]   pcOut,
  busca_instrucao_if.master bus
);

  import processador_pkg::*;

  fetch_state_t r_state;
  fetch_state_t w_next;

  logic [DATA_W-1:0] r_instr;
  logic [3:0]        r_opcode;
  logic [3:0]        r_operando;
  logic              r_valid;
  logic              r_halted;

  logic [PC_W-1:0]   w_pc;
  logic [PC_W-1:0]   w_target;
  logic [3:0]        w_op;
  logic [3:0]        w_opr;
  logic              w_is_halt;
  logic              w_is_jump;
  logic              w_load;
  logic              w_inc;
  logic              w_issue;

  assign w_op      = r_instr[DATA_W-1 -: 4];
  assign w_opr     = r_instr[3:0];
  assign w_is_halt = (w_op == OP_HALT);
  assign w_is_jump = (w_op == OP_JUMP);
  assign w_target  = PC_W'(w_opr);

  contador_programa #(
    .PC_W (PC_W)
  ) u_pc (
    .clock   (clock),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_inc   (w_inc),
    .i_din   (w_target),
    .o_pc    (w_pc)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_inc   = 1'b0;
    w_issue = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_next = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        w_next = ST_DECODE;
      end
      ST_DECODE: begin
        unique case (1'b1)
          w_is_halt: begin
            w_next = ST_HALTED;
          end
          w_is_jump: begin
            w_load = 1'b1;
            w_next = ST_FETCH;
          end
          default: begin
            w_issue = 1'b1;
            w_next  = ST_ISSUE;
          end
        endcase
      end
      ST_ISSUE: begin
        if (bus.ucDone) begin
          w_inc  = 1'b1;
          w_next = ST_FETCH;
        end
      end
      ST_HALTED: begin
        w_next = ST_HALTED;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Issue registers return to NOP on completion so that
  // repeated instructions still show an opcode edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr    <= '0;
      r_opcode   <= '0;
      r_operando <= '0;
      r_valid    <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if (r_state == ST_MEM_WAIT) begin
        r_instr <= bus.progData;
      end
      if (w_issue) begin
        r_opcode   <= w_op;
        r_operando <= w_opr;
        r_valid    <= 1'b1;
      end else if (w_inc) begin
        r_opcode   <= '0;
        r_operando <= '0;
        r_valid    <= 1'b0;
      end
      if (r_state == ST_DECODE && w_is_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  assign bus.progRd     = (r_state == ST_FETCH);
  assign bus.progAddr   = w_pc;
  assign bus.opcode     = r_opcode;
  assign bus.operando   = r_operando;
  assign bus.instrValid = r_valid;
  assign halted         = r_halted;
  assign pcOut          = w_pc;

endmodule

// File: tb/tb_busca_instrucao.sv
// Bench for busca_instrucao: directed and random programs
// checked against a program-level reference model.
module tb_busca_instrucao;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       ucDone = 1'b0;
  logic       halted;
  logic [3:0] pcOut;
  logic [7:0] rdata = 8'h00;

  logic [7:0] mem  [16];
  logic [7:0] memA [16];
  logic [7:0] memB [16];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int cref;

  int rd_q[$];
  int er_q[$];
  int eq_op[$];
  int eq_opr[$];
  int eq_pc[$];
  int eq_j[$];
  int h_pc;
  int h_j;
  bit h_ok;

  busca_instrucao_if #(.PC_W(4), .DATA_W(8)) bus ();

  assign bus.progData = rdata;
  assign bus.ucDone   = ucDone;

  busca_instrucao #(
    .PC_W   (4),
    .DATA_W (8)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .halted  (halted),
    .pcOut   (pcOut),
    .bus     (bus.master)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (bus.progRd) begin
      rdata <= mem[bus.progAddr];
      if (reset_n) rd_q.push_back(int'(bus.progAddr));
    end
  end

  task automatic chk(input string tag, input int got,
                     input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Executes the program as a list of fetches and issues.
  task automatic model_run(input bit rw);
    int pc;
    int j;
    logic [7:0] pm [16];
    logic [7:0] b;
    pc = 0;
    j  = 0;
    pm = memA;
    h_ok = 1'b0;
    er_q.delete();
    eq_op.delete();
    eq_opr.delete();
    eq_pc.delete();
    eq_j.delete();
    for (int s = 0; s < 64; s++) begin
      b = pm[pc];
      er_q.push_back(pc);
      if (b[7:4] == 4'hF) begin
        h_pc = pc;
        h_j  = j;
        h_ok = 1'b1;
        break;
      end
      if (b[7:4] == 4'hE) begin
        pc = int'(b[3:0]);
        j++;
        continue;
      end
      eq_op.push_back(int'(b[7:4]));
      eq_opr.push_back(int'(b[3:0]));
      eq_pc.push_back(pc);
      eq_j.push_back(j);
      j  = 0;
      pc = (pc + 1) % 16;
      if (rw && eq_op.size() == 1) pm = memB;
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) begin
      memA[i] = 8'hF0;
      memB[i] = 8'hF0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    start   = 1'b0;
    ucDone  = 1'b0;
    @(negedge clock);
    chk("rst_rd", bus.progRd, 0);
    chk("rst_addr", bus.progAddr, 0);
    chk("rst_op", bus.opcode, 0);
    chk("rst_opr", bus.operando, 0);
    chk("rst_vld", bus.instrValid, 0);
    chk("rst_halt", halted, 0);
    chk("rst_pc", pcOut, 0);
    @(negedge clock);
    reset_n = 1'b1;
    rd_q.delete();
  endtask

  task automatic gap_checks(input bit hold);
    chk("nop_op", {bus.opcode, bus.operando}, 0);
    chk("nop_halt", halted, 0);
    start = 1'($urandom_range(0, 1));
    if (!hold) ucDone = 1'($urandom_range(0, 1));
  endtask

  task automatic run_prog(input bit hold, input bit rw,
                          input int dly);
    bit got;
    int d;
    int ex;
    model_run(rw);
    mem = memA;
    do_reset();
    ucDone = hold;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cref  = cyc;
    for (int k = 0; k < eq_op.size(); k++) begin
      got = 1'b0;
      for (int w = 0; w < 60 && !got; w++) begin
        @(negedge clock);
        if (bus.instrValid) got = 1'b1;
        else gap_checks(hold);
      end
      if (!got) begin
        chk("issue_timeout", 0, 1);
        start  = 1'b0;
        ucDone = 1'b0;
        return;
      end
      start = 1'b0;
      ex = (eq_op[k] << 4) | eq_opr[k];
      chk("issue_lat", cyc - cref, 3 + 3 * eq_j[k]);
      chk("issue_instr", {bus.opcode, bus.operando}, ex);
      chk("issue_pc", pcOut, eq_pc[k]);
      if (rw && k == 0) mem = memB;
      d = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
      if (!hold) begin
        ucDone = 1'b0;
        for (int i = 0; i < d; i++) begin
          @(negedge clock);
          chk("hold_vld", bus.instrValid, 1);
          chk("hold_instr", {bus.opcode, bus.operando}, ex);
        end
        ucDone = 1'b1;
      end
      @(negedge clock);
      cref = cyc;
      if (!hold) ucDone = 1'b0;
      chk("drop_vld", bus.instrValid, 0);
      chk("drop_instr", {bus.opcode, bus.operando}, 0);
    end
    if (h_ok) begin
      got = 1'b0;
      for (int w = 0; w < 60 && !got; w++) begin
        @(negedge clock);
        if (halted) got = 1'b1;
        else gap_checks(hold);
      end
      chk("halt_seen", got, 1);
      chk("halt_lat", cyc - cref, 3 + 3 * h_j);
      chk("halt_pc", pcOut, h_pc);
      for (int i = 0; i < 4; i++) begin
        start  = 1'($urandom_range(0, 1));
        ucDone = 1'($urandom_range(0, 1));
        @(negedge clock);
        chk("halt_keep", halted, 1);
        chk("halt_frz", pcOut, h_pc);
        chk("halt_vld", bus.instrValid, 0);
      end
    end
    start  = 1'b0;
    ucDone = 1'b0;
    chk("n_reads", rd_q.size(), er_q.size());
    for (int i = 0; i < rd_q.size() && i < er_q.size(); i++)
      chk("read_addr", rd_q[i], er_q[i]);
  endtask

  task automatic reset_mid_issue();
    bit got;
    fill_mem();
    memA[0] = 8'hC3;
    memA[1] = 8'hD5;
    mem = memA;
    do_reset();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge clock);
      if (bus.instrValid) got = 1'b1;
    end
    chk("mid_issue_seen", got, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_vld", bus.instrValid, 0);
    chk("async_op", {bus.opcode, bus.operando}, 0);
    chk("async_pc", pcOut, 0);
    chk("async_addr", bus.progAddr, 0);
    chk("async_rd", bus.progRd, 0);
    chk("async_halt", halted, 0);
    @(negedge clock);
    reset_n = 1'b1;
    rd_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("idle_rd", bus.progRd, 0);
    end
    chk("idle_reads", rd_q.size(), 0);
  endtask

  initial begin
    reset_mid_issue();

    fill_mem();
    memA[0] = 8'hC3;
    memA[1] = 8'hD5;
    memA[2] = 8'hF0;
    run_prog(1'b0, 1'b0, 2);

    fill_mem();
    memA[0]  = 8'hE9;
    memA[1]  = 8'hC8;
    memA[9]  = 8'hC1;
    memA[10] = 8'hF0;
    run_prog(1'b0, 1'b0, 1);

    fill_mem();
    memA[0]  = 8'hEF;
    memA[15] = 8'hC7;
    memB     = memA;
    memB[0]  = 8'hD2;
    memB[1]  = 8'hF0;
    run_prog(1'b0, 1'b1, -1);

    fill_mem();
    memA[0] = 8'hC3;
    memA[1] = 8'hD5;
    memA[2] = 8'h01;
    memA[3] = 8'hF0;
    run_prog(1'b1, 1'b0, 0);

    fill_mem();
    memA[0] = 8'hC4;
    memA[1] = 8'hC4;
    memA[2] = 8'hF0;
    run_prog(1'b0, 1'b0, 0);

    for (int p = 0; p < 10; p++) begin
      fill_mem();
      for (int i = 0; i < 15; i++) begin
        case ($urandom_range(0, 9))
          0: memA[i] = {4'hF, 4'($urandom_range(0, 15))};
          1: memA[i] = {4'hE, 4'($urandom_range(i + 1, 15))};
          default:
            memA[i] = {4'($urandom_range(0, 13)),
                       4'($urandom_range(0, 15))};
        endcase
      end
      memA[15] = 8'hF0;
      run_prog(1'($urandom_range(0, 1)), 1'b0, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
